// File: rtl/sound_pkg.sv
// Shared types and constants for the alarm/sound scheduler.
package sound_pkg;

    typedef enum logic [1:0] {
        RS_IDLE   = 2'b00,
        RS_RING   = 2'b01,
        RS_SNOOZE = 2'b10
    } ring_state_t;

    localparam logic [5:0] NOTE_SILENT    = 6'd63;
    localparam logic [5:0] BEEP_NOTE_DEF  = 6'd27;
    localparam logic [5:0] CHIME_NOTE_DEF = 6'd22;

endpackage

// File: rtl/sound_sched_if.sv
// Note-bus interface: event pulses and song note in, buzzer note/player enable/LED state out.
interface sound_sched_if;
    import sound_pkg::*;

    logic        msecclk;
    logic        alarm_hit;
    logic        stop_btn;
    logic        snooze_btn;
    logic        key_beep;
    logic        chime_req;
    logic [5:0]  alarm_note;
    logic        song_do;
    logic [5:0]  music;
    ring_state_t ring_state;

    modport master (
        output msecclk, alarm_hit, stop_btn, snooze_btn, key_beep, chime_req, alarm_note,
        input  song_do, music, ring_state
    );

    modport slave (
        input  msecclk, alarm_hit, stop_btn, snooze_btn, key_beep, chime_req, alarm_note,
        output song_do, music, ring_state
    );
endinterface

// File: rtl/ms_countdown.sv
// Millisecond countdown: load sets LOAD_VAL, each msecclk decrements toward zero.
// active is the registered nonzero flag; active_next is the value it takes after this clk,
// which lets the parent register its outputs with a single clk of latency.
module ms_countdown #(
    parameter int unsigned LOAD_VAL = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic msecclk,
    input  logic load,
    output logic active,
    output logic active_next
);
    localparam int W = (LOAD_VAL > 0) ? $clog2(LOAD_VAL + 1) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    // Reload takes priority over a coinciding tick so a retrigger always gets the full length.
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = W'(LOAD_VAL);
        else if (msecclk && cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign active      = (cnt_q != '0);
    assign active_next = (cnt_d != '0);
endmodule

// File: rtl/sound_sched.sv
// Alarm/sound scheduler: ring/snooze FSM with ms timeouts plus priority mux of the buzzer
// note bus (beep > alarm song > hourly chime > silence).
// Optional feature macro: SOUND_SNOOZE_EN (snooze state and its timer compare).
module sound_sched
    import sound_pkg::*;
#(
    parameter int unsigned RING_MS_MAX = 60000,
    parameter int unsigned SNOOZE_MS   = 300000,
    parameter int unsigned BEEP_MS     = 50,
    parameter int unsigned CHIME_MS    = 200,
    parameter logic [5:0]  BEEP_NOTE   = BEEP_NOTE_DEF,
    parameter logic [5:0]  CHIME_NOTE  = CHIME_NOTE_DEF
) (
    input logic           clk,
    input logic           rst,
    sound_sched_if.slave  bus
);
    localparam int unsigned MS_MAX = (RING_MS_MAX > SNOOZE_MS) ? RING_MS_MAX : SNOOZE_MS;
    localparam int          CNT_W  = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;
    localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_MS_MAX - 1);

    ring_state_t      state_q, state_d;
    logic [CNT_W-1:0] ms_cnt_q, ms_cnt_d;
    logic [5:0]       music_q, music_d;
    logic             song_do_q, song_do_d;
    logic             beep_act, beep_nx, chime_act, chime_nx, chime_ld;

    // A chime is only accepted from a quiet idle; anything else drops the request.
    assign chime_ld = bus.chime_req && (state_q == RS_IDLE) && !chime_act;

    ms_countdown #(.LOAD_VAL(BEEP_MS)) u_beep (
        .clk(clk), .rst(rst), .msecclk(bus.msecclk), .load(bus.key_beep),
        .active(beep_act), .active_next(beep_nx)
    );

    ms_countdown #(.LOAD_VAL(CHIME_MS)) u_chime (
        .clk(clk), .rst(rst), .msecclk(bus.msecclk), .load(chime_ld),
        .active(chime_act), .active_next(chime_nx)
    );

`ifndef SOUND_SNOOZE_EN
    logic unused_snooze;
    assign unused_snooze = bus.snooze_btn ^ beep_act;
`endif

    // State and ms timer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RS_IDLE;
            ms_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ms_cnt_q <= ms_cnt_d;
        end
    end

    // Next-state: stop beats snooze beats timeout; alarm_hit only matters from idle.
    always_comb begin
        state_d  = state_q;
        ms_cnt_d = ms_cnt_q;
        case (state_q)
            RS_IDLE: begin
                ms_cnt_d = '0;
                if (bus.alarm_hit) state_d = RS_RING;
            end
            RS_RING: begin
                if (bus.stop_btn) begin
                    state_d  = RS_IDLE;
                    ms_cnt_d = '0;
`ifdef SOUND_SNOOZE_EN
                end else if (bus.snooze_btn) begin
                    state_d  = RS_SNOOZE;
                    ms_cnt_d = '0;
`endif
                end else if (bus.msecclk) begin
                    if (ms_cnt_q == RING_LAST) begin
                        state_d  = RS_IDLE;
                        ms_cnt_d = '0;
                    end else begin
                        ms_cnt_d = ms_cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef SOUND_SNOOZE_EN
            RS_SNOOZE: begin
                if (bus.stop_btn) begin
                    state_d  = RS_IDLE;
                    ms_cnt_d = '0;
                end else if (bus.msecclk) begin
                    if (ms_cnt_q == CNT_W'(SNOOZE_MS - 1)) begin
                        state_d  = RS_RING;
                        ms_cnt_d = '0;
                    end else begin
                        ms_cnt_d = ms_cnt_q + CNT_W'(1);
                    end
                end
            end
`endif
            default: begin
                state_d  = RS_IDLE;
                ms_cnt_d = '0;
            end
        endcase
    end

    // Output decode from next-cycle values so the registered outputs lag inputs by one clk.
    always_comb begin
        song_do_d = (state_d == RS_RING);
        if (beep_nx)                 music_d = BEEP_NOTE;
        else if (state_d == RS_RING) music_d = bus.alarm_note;
        else if (chime_nx)           music_d = CHIME_NOTE;
        else                         music_d = NOTE_SILENT;
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            music_q   <= NOTE_SILENT;
            song_do_q <= 1'b0;
        end else begin
            music_q   <= music_d;
            song_do_q <= song_do_d;
        end
    end

    assign bus.music      = music_q;
    assign bus.song_do    = song_do_q;
    assign bus.ring_state = state_q;
endmodule

// File: tb/tb_sound_sched.sv
// Directed bench for sound_sched with shortened timers (ring 100, snooze 50, beep 5, chime 10 ms).
module tb_sound_sched;
    import sound_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    sound_sched_if bus();

    sound_sched #(
        .RING_MS_MAX(100), .SNOOZE_MS(50), .BEEP_MS(5), .CHIME_MS(10)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clk; afterwards outputs reflect the edge just taken.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.msecclk = 1'b1; cyc();
            bus.msecclk = 1'b0; cyc();
        end
    endtask

    task automatic outs(input string tag, input logic [1:0] rs, input logic sd, input logic [5:0] mu);
        chk({tag, ".ring"},  32'(bus.ring_state), 32'(rs));
        chk({tag, ".song"},  32'(bus.song_do),    32'(sd));
        chk({tag, ".music"}, 32'(bus.music),      32'(mu));
    endtask

    task automatic hit();   bus.alarm_hit = 1'b1;  cyc(); bus.alarm_hit = 1'b0;  endtask
    task automatic stop();  bus.stop_btn = 1'b1;   cyc(); bus.stop_btn = 1'b0;   endtask
    task automatic beep();  bus.key_beep = 1'b1;   cyc(); bus.key_beep = 1'b0;   endtask
    task automatic chime(); bus.chime_req = 1'b1;  cyc(); bus.chime_req = 1'b0;  endtask

    initial begin
        bus.msecclk = 0; bus.alarm_hit = 0; bus.stop_btn = 0; bus.snooze_btn = 0;
        bus.key_beep = 0; bus.chime_req = 0; bus.alarm_note = 6'd19;

        // reset held, alarm_hit ignored
        rst = 1'b1;
        repeat (3) cyc();
        outs("rst", 2'b00, 1'b0, 6'd63);
        hit();
        outs("rst_hit", 2'b00, 1'b0, 6'd63);
        rst = 1'b0; cyc();

        // idle buttons ignored
        stop();
        outs("idle_stop", 2'b00, 1'b0, 6'd63);

        // ring, re-hit ignored, timeout at 100 ticks
        hit();
        outs("ring", 2'b01, 1'b1, 6'd19);
        bus.alarm_note = 6'd7; cyc();
        chk("note_follow", 32'(bus.music), 32'd7);
        bus.alarm_note = 6'd19;
        ticks(50);
        hit();
        ticks(49);
        outs("ring99", 2'b01, 1'b1, 6'd19);
        ticks(1);
        outs("timeout", 2'b00, 1'b0, 6'd63);

        // beep preempts song, ring timer unaffected
        hit();
        ticks(10);
        beep();
        outs("beep", 2'b01, 1'b1, 6'd27);
        ticks(4);
        chk("beep4", 32'(bus.music), 32'd27);
        ticks(1);
        chk("beep_end", 32'(bus.music), 32'd19);
        ticks(84);
        chk("ring_after_beep", 32'(bus.ring_state), 32'd1);
        ticks(1);
        outs("timeout2", 2'b00, 1'b0, 6'd63);

        // chime in idle
        chime();
        chk("chime", 32'(bus.music), 32'd22);
        ticks(9);
        chk("chime9", 32'(bus.music), 32'd22);
        ticks(1);
        chk("chime_end", 32'(bus.music), 32'd63);

        // chime during ring dropped
        hit();
        chime();
        chk("chime_in_ring", 32'(bus.music), 32'd19);
        stop();
        outs("stop", 2'b00, 1'b0, 6'd63);
        ticks(1);
        chk("no_chime_after", 32'(bus.music), 32'd63);

`ifdef SOUND_SNOOZE_EN
        // snooze, re-ring after 50 ticks, stop wins over snooze
        hit();
        bus.snooze_btn = 1'b1; cyc(); bus.snooze_btn = 1'b0;
        outs("snooze", 2'b10, 1'b0, 6'd63);
        ticks(49);
        chk("snooze49", 32'(bus.ring_state), 32'd2);
        ticks(1);
        outs("rering", 2'b01, 1'b1, 6'd19);
        bus.snooze_btn = 1'b1; bus.stop_btn = 1'b1; cyc();
        bus.snooze_btn = 1'b0; bus.stop_btn = 1'b0;
        outs("stop_wins", 2'b00, 1'b0, 6'd63);
`else
        // snooze not built: button has no effect
        hit();
        bus.snooze_btn = 1'b1; cyc(); bus.snooze_btn = 1'b0;
        outs("no_snooze", 2'b01, 1'b1, 6'd19);
        stop();
        chk("no_snooze_stop", 32'(bus.ring_state), 32'd0);
`endif

        // reset mid-ring with beep active
        hit();
        beep();
        rst = 1'b1; cyc(); rst = 1'b0;
        outs("rst_mid", 2'b00, 1'b0, 6'd63);
        cyc();
        chk("rst_beep_clr", 32'(bus.music), 32'd63);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
